ysyx_220066_wb_arbiter: RTL and testbench
=========================================

Name: ysyx_220066_wb_arbiter

Overview:
- Shares the single register-file write port between the memory, divider and multiplier result paths, in front of the writeback stage.
- Each source hands over one result via valid/ready into a one-entry holding buffer.
- Default arbitration is fixed priority: memory > divider > multiplier.
- A per-source wait counter forces a grant once a source has waited STARVE_LIMIT cycles, so low-priority units cannot starve.

Parameters:
- XLEN, 64, data and PC width.
- STARVE_LIMIT, 4, wait cycles after which a buffered source is force-granted; legal range 1..15.
- CNT_W, 4, wait-counter width; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- m_valid, div_valid, mul_valid  in  1 each  source holds a result
- m_ready, div_ready, mul_ready  out  1 each  buffer can accept this cycle
- m_rd, div_rd, mul_rd  in  5 each  destination register
- m_data, div_data, mul_data  in  XLEN each  result
- m_nxtpc, div_nxtpc, mul_nxtpc  in  XLEN each  next PC of the retiring instruction
- m_error, div_error, mul_error  in  1 each  fault flag
- wb_valid  out  1  an instruction retires this cycle
- rf_wen  out  1  register-file write enable (wb_valid && rf_rd != 0 && !wb_error)
- rf_rd  out  5  write register
- rf_data  out  XLEN  write data
- wb_nxtpc  out  XLEN  retiring next PC
- wb_error  out  1  retiring fault
- wb_src  out  2  winner: 0 = mem, 1 = div, 2 = mul, 3 = none

Behaviour:
- Reset (rst_n low, asynchronous):
  - all buffer valids, wait counters and wb_valid go to 0.
  - rf_rd, rf_data, wb_nxtpc and wb_error go to 0; wb_src goes to 3.
  - Buffer payloads may be left un-reset.
- Accept: s_ready = !flush && (!buf_v[s] || grant[s]). A transfer happens at a rising edge when s_valid && s_ready, and the payload is written into buf[s].
- Grant (combinational on buffer state, one-hot or none):
  - Starved set = sources with buf_v set and cnt == STARVE_LIMIT.
  - If the starved set is non-empty, grant its highest-priority member.
  - Otherwise grant the highest-priority source with buf_v set.
- Output stage is registered.
  - At each edge: wb_valid <= any grant && !flush, and the winner's payload is loaded into the output registers.
  - If there is no winner, wb_valid <= 0, wb_src <= 3, and the payload registers hold their value.
- Latency: a source valid in cycle 0 with an empty buffer and no competitor gives wb_valid=1 in cycle 2. Throughput is 1 retire per cycle.
- Granted buffer in the same cycle as a new transfer: the buffer is refilled, not cleared (bypass-free skid).
- Wait counter:
  - Increments each cycle buf_v[s] && !grant[s], saturating at STARVE_LIMIT.
  - Clears on grant, flush or reset.
- Flush (synchronous, highest precedence over accept and grant):
  - clears all buf_v, all counters and wb_valid at the next edge.
  - All s_ready are 0 in the flush cycle.
  - Results in flight are dropped.
- rd == 0: the instruction still retires (wb_valid=1), but rf_wen=0.
- Error: wb_error=1 forces rf_wen=0. The result still retires, so commit logic sees wb_nxtpc.
- Simultaneous equal starvation: lowest wb_src index wins; the loser keeps its saturated count and wins next.
- No reordering within a source; cross-source order follows arbitration only.

Decomposition:
- Shared package holds:
  - source-index constants SRC_MEM=0, SRC_DIV=1, SRC_MUL=2, SRC_NONE=3;
  - the wb payload struct {rd, data, nxtpc, error}.
- One sub-module, ysyx_220066_wb_slot, instantiated three times. It contains the one-entry buffer, the ready logic and the saturating wait counter.
- Grant logic and the output register stay in the top module.

Test Plan:
- Single source: mul_valid=1 with rd=5, data=0x1234 in cycle 0 only -> cycle 2 shows wb_valid=1, rf_wen=1, rf_rd=5, rf_data=0x1234, wb_src=2. Cycle 3 shows wb_valid=0.
- Priority: m, div and mul each push once in the same cycle -> retire order mem, div, mul in cycles 2, 3, 4. All ready return to 1 by cycle 3.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: m_valid held high continuously; mul pushes once in cycle 0.
  - Required: mul waits 4 cycles, then is force-granted; its result appears with wb_src=2 in cycle 6.
  - Required: m_ready drops for exactly one cycle around the forced grant, and no memory result is lost.
- Flush: fill all three buffers, assert flush for 1 cycle -> next cycle wb_valid=0 and all buffers empty; all ready=0 during the flush cycle. A subsequent push retires normally 2 cycles later.
- x0 and error:
  - m_rd=0, data=0xFF -> wb_valid=1, rf_wen=0.
  - div_error=1, rd=7 -> wb_valid=1, wb_error=1, rf_wen=0.
- Async reset: drop rst_n mid-cycle while buffers are full -> wb_valid=0 and wb_src=3 immediately, without waiting for a clock edge. After release, there are no spurious retires.

Source files
------------

// File: rtl/ysyx_220066_wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: source indices, the buffered
// result payload, and a lowest-index-first picker used by the grant logic.
package ysyx_220066_wb_arbiter_pkg;

  localparam int WB_XLEN = 64;
  localparam int NUM_SRC = 3;

  typedef enum logic [1:0] {
    SRC_MEM  = 2'd0,
    SRC_DIV  = 2'd1,
    SRC_MUL  = 2'd2,
    SRC_NONE = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
    logic [WB_XLEN-1:0] nxtpc;
    logic               error;
  } wb_payload_t;

  // Lower index means higher priority, so isolating the lowest set bit is the pick
  function automatic logic [NUM_SRC-1:0] pick_first(input logic [NUM_SRC-1:0] req);
    pick_first = req & (~req + NUM_SRC'(1));
  endfunction

endpackage

// File: rtl/ysyx_220066_wb_arbiter_if.sv
// Bus between the three result producers, the arbiter and the writeback stage.
// The master side is the producers plus the writeback consumer; the slave side is the arbiter.
interface ysyx_220066_wb_arbiter_if #(
  parameter int XLEN = 64
);

  logic            m_valid;
  logic            m_ready;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  logic [XLEN-1:0] m_nxtpc;
  logic            m_error;

  logic            div_valid;
  logic            div_ready;
  logic [4:0]      div_rd;
  logic [XLEN-1:0] div_data;
  logic [XLEN-1:0] div_nxtpc;
  logic            div_error;

  logic            mul_valid;
  logic            mul_ready;
  logic [4:0]      mul_rd;
  logic [XLEN-1:0] mul_data;
  logic [XLEN-1:0] mul_nxtpc;
  logic            mul_error;

  logic            wb_valid;
  logic            rf_wen;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_data;
  logic [XLEN-1:0] wb_nxtpc;
  logic            wb_error;
  logic [1:0]      wb_src;

  modport master (
    output m_valid, m_rd, m_data, m_nxtpc, m_error,
    output div_valid, div_rd, div_data, div_nxtpc, div_error,
    output mul_valid, mul_rd, mul_data, mul_nxtpc, mul_error,
    input  m_ready, div_ready, mul_ready,
    input  wb_valid, rf_wen, rf_rd, rf_data, wb_nxtpc, wb_error, wb_src
  );

  modport slave (
    input  m_valid, m_rd, m_data, m_nxtpc, m_error,
    input  div_valid, div_rd, div_data, div_nxtpc, div_error,
    input  mul_valid, mul_rd, mul_data, mul_nxtpc, mul_error,
    output m_ready, div_ready, mul_ready,
    output wb_valid, rf_wen, rf_rd, rf_data, wb_nxtpc, wb_error, wb_src
  );

endinterface

// File: rtl/ysyx_220066_wb_arbiter_slot.sv
// One-entry holding buffer for a single result source, with its accept logic
// and a saturating counter of how long the held result has been passed over.
module ysyx_220066_wb_slot
  import ysyx_220066_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        src_valid,
  output logic        src_ready,
  input  wb_payload_t src_payload,
  input  logic        grant,
  output logic        buf_v,
  output logic        starved,
  output wb_payload_t buf_payload
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;
  logic             accept;

  // A granted entry leaves at this edge, so its slot can be refilled in the same cycle
  assign src_ready = !flush && (!buf_v || grant);
  assign accept    = src_valid && src_ready;
  assign starved   = buf_v && (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v <= 1'b0;
      cnt   <= '0;
    end else if (flush) begin
      buf_v <= 1'b0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        buf_v <= 1'b1;
      end else if (grant) begin
        buf_v <= 1'b0;
      end
      if (grant) begin
        cnt <= '0;
      end else if (buf_v && (cnt != LIMIT)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Payload is qualified by buf_v, so it carries no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_payload <= src_payload;
    end
  end

endmodule

// File: rtl/ysyx_220066_wb_arbiter.sv
// Writeback arbiter: buffers one result per source and retires at most one per
// cycle through the register-file write port, fixed priority with anti-starvation.
module ysyx_220066_wb_arbiter
  import ysyx_220066_wb_arbiter_pkg::*;
#(
  parameter int XLEN         = WB_XLEN,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic                     flush,
  ysyx_220066_wb_arbiter_if.slave bus
);

  logic [NUM_SRC-1:0] valid_vec;
  logic [NUM_SRC-1:0] ready_vec;
  logic [NUM_SRC-1:0] buf_v;
  logic [NUM_SRC-1:0] starved;
  logic [NUM_SRC-1:0] grant;
  wb_payload_t        in_p  [NUM_SRC];
  wb_payload_t        buf_p [NUM_SRC];

  wb_src_e     win_src;
  wb_payload_t win_payload;

  logic        wb_valid_q;
  wb_src_e     wb_src_q;
  wb_payload_t out_q;

  assign valid_vec = {bus.mul_valid, bus.div_valid, bus.m_valid};
  assign in_p[SRC_MEM] = '{rd: bus.m_rd,   data: bus.m_data,   nxtpc: bus.m_nxtpc,   error: bus.m_error};
  assign in_p[SRC_DIV] = '{rd: bus.div_rd, data: bus.div_data, nxtpc: bus.div_nxtpc, error: bus.div_error};
  assign in_p[SRC_MUL] = '{rd: bus.mul_rd, data: bus.mul_data, nxtpc: bus.mul_nxtpc, error: bus.mul_error};

  assign bus.m_ready   = ready_vec[SRC_MEM];
  assign bus.div_ready = ready_vec[SRC_DIV];
  assign bus.mul_ready = ready_vec[SRC_MUL];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    ysyx_220066_wb_slot #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .CNT_W       (CNT_W)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .src_valid  (valid_vec[i]),
      .src_ready  (ready_vec[i]),
      .src_payload(in_p[i]),
      .grant      (grant[i]),
      .buf_v      (buf_v[i]),
      .starved    (starved[i]),
      .buf_payload(buf_p[i])
    );
  end

  // Starved entries pre-empt normal priority; ties among them still go by priority
  always_comb begin
    grant = '0;
    if (starved != '0) begin
      grant = pick_first(starved);
    end else begin
      grant = pick_first(buf_v);
    end
  end

  always_comb begin
    win_src     = SRC_NONE;
    win_payload = buf_p[SRC_MEM];
    if (grant[SRC_MEM]) begin
      win_src     = SRC_MEM;
      win_payload = buf_p[SRC_MEM];
    end else if (grant[SRC_DIV]) begin
      win_src     = SRC_DIV;
      win_payload = buf_p[SRC_DIV];
    end else if (grant[SRC_MUL]) begin
      win_src     = SRC_MUL;
      win_payload = buf_p[SRC_MUL];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_src_q   <= SRC_NONE;
      out_q      <= '0;
    end else if (flush) begin
      wb_valid_q <= 1'b0;
      wb_src_q   <= SRC_NONE;
    end else if (grant != '0) begin
      wb_valid_q <= 1'b1;
      wb_src_q   <= win_src;
      out_q      <= win_payload;
    end else begin
      wb_valid_q <= 1'b0;
      wb_src_q   <= SRC_NONE;
    end
  end

  // Faulting and x0-targeted results still retire but must not write the register file
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_src   = wb_src_q;
  assign bus.rf_rd    = out_q.rd;
  assign bus.rf_data  = out_q.data[XLEN-1:0];
  assign bus.wb_nxtpc = out_q.nxtpc[XLEN-1:0];
  assign bus.wb_error = out_q.error;
  assign bus.rf_wen   = wb_valid_q && (out_q.rd != 5'd0) && !out_q.error;

endmodule

// File: tb/tb_ysyx_220066_wb_arbiter.sv
// Self-checking bench for the writeback arbiter: vector table for single retires,
// hand-written sequences for priority, starvation, flush and async reset, plus a per-source scoreboard.
module tb_ysyx_220066_wb_arbiter;
  import ysyx_220066_wb_arbiter_pkg::*;

  localparam int XLEN = 64;

  logic clk;
  logic rst_n;
  logic flush;

  ysyx_220066_wb_arbiter_if #(.XLEN(XLEN)) bus ();

  ysyx_220066_wb_arbiter #(
    .XLEN        (XLEN),
    .STARVE_LIMIT(4),
    .CNT_W       (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  src;
    wb_payload_t p;
    logic        exp_wen;
  } vec_t;

  int          tests_run;
  int          tests_failed;
  wb_payload_t q_mem[$];
  wb_payload_t q_div[$];
  wb_payload_t q_mul[$];
  vec_t        vecs[6];
  logic [1:0]  src_hist[16];
  logic [15:0] mready_hist;

  function automatic wb_payload_t mkp(input logic [4:0] rd, input logic [63:0] data,
                                      input logic [63:0] nxtpc, input logic err);
    wb_payload_t p;
    p.rd    = rd;
    p.data  = data;
    p.nxtpc = nxtpc;
    p.error = err;
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] src, input logic v, input wb_payload_t p);
    case (src)
      SRC_MEM: begin
        bus.m_valid = v; bus.m_rd = p.rd; bus.m_data = p.data; bus.m_nxtpc = p.nxtpc; bus.m_error = p.error;
      end
      SRC_DIV: begin
        bus.div_valid = v; bus.div_rd = p.rd; bus.div_data = p.data; bus.div_nxtpc = p.nxtpc; bus.div_error = p.error;
      end
      default: begin
        bus.mul_valid = v; bus.mul_rd = p.rd; bus.mul_data = p.data; bus.mul_nxtpc = p.nxtpc; bus.mul_error = p.error;
      end
    endcase
  endtask

  task automatic clearValid();
    bus.m_valid   = 1'b0;
    bus.div_valid = 1'b0;
    bus.mul_valid = 1'b0;
  endtask

  // Per-source in-order scoreboard: handshakes push, retires pop from the named source
  task automatic monitor();
    wb_payload_t exp_p;
    logic        got;
    if (!rst_n) begin
      q_mem.delete(); q_div.delete(); q_mul.delete();
      return;
    end
    if (bus.wb_valid) begin
      got   = 1'b0;
      exp_p = '0;
      case (bus.wb_src)
        SRC_MEM: if (q_mem.size() > 0) begin exp_p = q_mem.pop_front(); got = 1'b1; end
        SRC_DIV: if (q_div.size() > 0) begin exp_p = q_div.pop_front(); got = 1'b1; end
        SRC_MUL: if (q_mul.size() > 0) begin exp_p = q_mul.pop_front(); got = 1'b1; end
        default: got = 1'b0;
      endcase
      checkOutput("sb_retire_pending", {159'd0, got}, 160'd1);
      if (got) begin
        checkOutput("sb_payload",
                    {bus.rf_rd, bus.rf_data, bus.wb_nxtpc, bus.wb_error, bus.rf_wen},
                    {exp_p.rd, exp_p.data, exp_p.nxtpc, exp_p.error, (exp_p.rd != 5'd0) && !exp_p.error});
      end
    end
    if (flush) begin
      q_mem.delete(); q_div.delete(); q_mul.delete();
    end else begin
      if (bus.m_valid && bus.m_ready)
        q_mem.push_back(mkp(bus.m_rd, bus.m_data, bus.m_nxtpc, bus.m_error));
      if (bus.div_valid && bus.div_ready)
        q_div.push_back(mkp(bus.div_rd, bus.div_data, bus.div_nxtpc, bus.div_error));
      if (bus.mul_valid && bus.mul_ready)
        q_mul.push_back(mkp(bus.mul_rd, bus.mul_data, bus.mul_nxtpc, bus.mul_error));
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] readyVec();
    return {bus.m_ready, bus.div_ready, bus.mul_ready};
  endfunction

  // Memory streams continuously while mul (and optionally div) push once in cycle 0
  task automatic runStarve(input logic with_div);
    int m_seq;
    m_seq       = 0;
    mready_hist = '0;
    for (int c = 0; c < 14; c++) begin
      applyStimulus(SRC_MEM, 1'b1, mkp(5'd10 + 5'(m_seq % 4), 64'hA000 + 64'(m_seq),
                                       64'h8000_1000 + 64'(4 * m_seq), 1'b0));
      if (c == 0) begin
        applyStimulus(SRC_MUL, 1'b1, mkp(5'd12, 64'hBEEF_0002, 64'h8000_2000, 1'b0));
        if (with_div) applyStimulus(SRC_DIV, 1'b1, mkp(5'd11, 64'hBEEF_0001, 64'h8000_3000, 1'b0));
      end else begin
        bus.mul_valid = 1'b0;
        bus.div_valid = 1'b0;
      end
      mready_hist[c] = bus.m_ready;
      src_hist[c]    = bus.wb_src;
      if (bus.m_ready) m_seq++;
      step();
    end
    clearValid();
    repeat (4) step();
    checkOutput("starve_drained", 160'(q_mem.size() + q_div.size() + q_mul.size()), 160'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    for (int s = 0; s < 3; s++) applyStimulus(2'(s), 1'b0, '0);

    vecs[0] = '{src: SRC_MUL, p: mkp(5'd5,  64'h1234,                64'h8000_0004, 1'b0), exp_wen: 1'b1};
    vecs[1] = '{src: SRC_MEM, p: mkp(5'd0,  64'hFF,                  64'h8000_0008, 1'b0), exp_wen: 1'b0};
    vecs[2] = '{src: SRC_DIV, p: mkp(5'd7,  64'h5555_AAAA,           64'h8000_000C, 1'b1), exp_wen: 1'b0};
    vecs[3] = '{src: SRC_MEM, p: mkp(5'd31, 64'hDEAD_BEEF_CAFE_F00D, 64'h8000_0010, 1'b0), exp_wen: 1'b1};
    vecs[4] = '{src: SRC_DIV, p: mkp(5'd1,  64'h0123_4567_89AB_CDEF, 64'h8000_0014, 1'b0), exp_wen: 1'b1};
    vecs[5] = '{src: SRC_MUL, p: mkp(5'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0018, 1'b1), exp_wen: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {bus.wb_valid, bus.wb_src, bus.rf_wen, bus.rf_rd, bus.rf_data, bus.wb_nxtpc, bus.wb_error},
                {1'b0, 2'd3, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].src, 1'b1, vecs[i].p);
      step();
      clearValid();
      step();
      checkOutput($sformatf("vec%0d_retire", i),
                  {bus.wb_valid, bus.wb_src, bus.rf_wen, bus.wb_error, bus.rf_rd, bus.rf_data, bus.wb_nxtpc},
                  {1'b1, vecs[i].src, vecs[i].exp_wen, vecs[i].p.error, vecs[i].p.rd, vecs[i].p.data, vecs[i].p.nxtpc});
      step();
      checkOutput($sformatf("vec%0d_idle", i), {159'd0, bus.wb_valid}, 160'd0);
    end

    applyStimulus(SRC_MEM, 1'b1, mkp(5'd2, 64'h111, 64'h9000_0000, 1'b0));
    applyStimulus(SRC_DIV, 1'b1, mkp(5'd3, 64'h222, 64'h9000_0004, 1'b0));
    applyStimulus(SRC_MUL, 1'b1, mkp(5'd4, 64'h333, 64'h9000_0008, 1'b0));
    step();
    clearValid();
    checkOutput("prio_c1_ready", 160'(readyVec()), 160'(3'b100));
    step();
    checkOutput("prio_c2", {bus.wb_valid, bus.wb_src, bus.rf_data}, {1'b1, SRC_MEM, 64'h111});
    step();
    checkOutput("prio_c3", {bus.wb_valid, bus.wb_src, bus.rf_data}, {1'b1, SRC_DIV, 64'h222});
    checkOutput("prio_c3_ready", 160'(readyVec()), 160'(3'b111));
    step();
    checkOutput("prio_c4", {bus.wb_valid, bus.wb_src, bus.rf_data}, {1'b1, SRC_MUL, 64'h333});
    step();
    checkOutput("prio_c5_idle", {159'd0, bus.wb_valid}, 160'd0);

    runStarve(1'b0);
    checkOutput("starve_mready", 160'(mready_hist[13:0]), 160'(14'b11_1111_1101_1111));
    checkOutput("starve_src", {src_hist[1], src_hist[2], src_hist[5], src_hist[6], src_hist[7]},
                {SRC_NONE, SRC_MEM, SRC_MEM, SRC_MUL, SRC_MEM});

    runStarve(1'b1);
    checkOutput("tie_mready", 160'(mready_hist[13:0]), 160'(14'b11_1111_1001_1111));
    checkOutput("tie_src", {src_hist[5], src_hist[6], src_hist[7], src_hist[8]},
                {SRC_MEM, SRC_DIV, SRC_MUL, SRC_MEM});

    applyStimulus(SRC_MEM, 1'b1, mkp(5'd20, 64'h444, 64'hA000_0000, 1'b0));
    applyStimulus(SRC_DIV, 1'b1, mkp(5'd21, 64'h555, 64'hA000_0004, 1'b0));
    applyStimulus(SRC_MUL, 1'b1, mkp(5'd22, 64'h666, 64'hA000_0008, 1'b0));
    step();
    clearValid();
    flush = 1'b1;
    #1;
    checkOutput("flush_ready", 160'(readyVec()), 160'(3'b000));
    step();
    flush = 1'b0;
    #1;
    checkOutput("flush_wb_valid", {159'd0, bus.wb_valid}, 160'd0);
    checkOutput("flush_empty", 160'(readyVec()), 160'(3'b111));
    step();
    checkOutput("flush_no_retire", {159'd0, bus.wb_valid}, 160'd0);
    applyStimulus(SRC_DIV, 1'b1, mkp(5'd23, 64'h777, 64'hA000_000C, 1'b0));
    step();
    clearValid();
    step();
    checkOutput("post_flush_retire", {bus.wb_valid, bus.wb_src, bus.rf_data}, {1'b1, SRC_DIV, 64'h777});
    step();

    applyStimulus(SRC_MEM, 1'b1, mkp(5'd24, 64'h888, 64'hB000_0000, 1'b0));
    applyStimulus(SRC_DIV, 1'b1, mkp(5'd25, 64'h999, 64'hB000_0004, 1'b0));
    applyStimulus(SRC_MUL, 1'b1, mkp(5'd26, 64'hAAA, 64'hB000_0008, 1'b0));
    step();
    clearValid();
    step();
    checkOutput("pre_reset_valid", {bus.wb_valid, bus.wb_src}, {1'b1, SRC_MEM});
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out", {bus.wb_valid, bus.wb_src, bus.rf_wen}, {1'b0, SRC_NONE, 1'b0});
    checkOutput("async_reset_ready", 160'(readyVec()), 160'(3'b111));
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checkOutput($sformatf("post_reset_idle%0d", c), {bus.wb_valid, bus.wb_src}, {1'b0, SRC_NONE});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
